// File: rtl/s2p_pkg.sv
// Shared types and helpers for the serial-to-parallel converter.
// S_PARITY exists only when S2P_PARITY_EN is defined.
package s2p_pkg;

`ifdef S2P_PARITY_EN
    typedef enum logic [0:0] {
        S_DATA   = 1'b0,
        S_PARITY = 1'b1
    } s2p_state_e;
`else
    typedef enum logic [0:0] {
        S_DATA = 1'b0
    } s2p_state_e;
`endif

    // Bit counter must be able to hold 0..N.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_to_parallel_converter.sv
// Serial-to-parallel converter: MSB-first shift into an N-bit registered word with valid/ready on both sides.
// Optional even-parity check per word when S2P_PARITY_EN is defined (adds par_err).
module serial_to_parallel_converter
    import s2p_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ser_data,
    input  logic         ser_valid,
    output logic         ser_ready,
    output logic [N-1:0] par_data,
    output logic         par_valid,
    input  logic         par_ready
`ifdef S2P_PARITY_EN
    ,
    output logic         par_err
`endif
);

    localparam int unsigned CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_DATA = CW'(N - 1);

    s2p_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   sh_q, sh_d;
    logic [N-1:0]   par_data_q, par_data_d;
    logic           par_valid_q, par_valid_d;
`ifdef S2P_PARITY_EN
    logic           par_err_q, par_err_d;
`endif

    logic           word_last;
    logic           ready_c;
    logic           accept;

    // Next-state: bit acceptance, shifting, FSM and output register update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        par_data_d  = par_data_q;
        par_valid_d = par_valid_q;
`ifdef S2P_PARITY_EN
        par_err_d   = par_err_q;
        word_last   = (state_q == S_PARITY);
`else
        word_last   = (state_q == S_DATA) && (cnt_q == LAST_DATA);
`endif
        // Stall only the word-completing bit while the output slot cannot drain.
        ready_c = !rst && !(word_last && par_valid_q && !par_ready);
        accept  = ser_valid && ready_c;

        if (par_valid_q && par_ready) begin
            par_valid_d = 1'b0;
        end

        if (accept) begin
            unique case (state_q)
                S_DATA: begin
                    sh_d = {sh_q[N-2:0], ser_data};
                    if (cnt_q == LAST_DATA) begin
`ifdef S2P_PARITY_EN
                        state_d = S_PARITY;
                        cnt_d   = CW'(N);
`else
                        cnt_d       = '0;
                        par_data_d  = {sh_q[N-2:0], ser_data};
                        par_valid_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`ifdef S2P_PARITY_EN
                S_PARITY: begin
                    state_d     = S_DATA;
                    cnt_d       = '0;
                    par_data_d  = sh_q;
                    par_valid_d = 1'b1;
                    par_err_d   = ^{sh_q, ser_data};
                end
`endif
                default: ;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_DATA;
            cnt_q       <= '0;
            sh_q        <= '0;
            par_data_q  <= '0;
            par_valid_q <= 1'b0;
`ifdef S2P_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            par_data_q  <= par_data_d;
            par_valid_q <= par_valid_d;
`ifdef S2P_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign ser_ready = ready_c;
    assign par_data  = par_data_q;
    assign par_valid = par_valid_q;
`ifdef S2P_PARITY_EN
    assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_serial_to_parallel_converter.sv
// Scoreboard bench for serial_to_parallel_converter (N=4); builds with or without S2P_PARITY_EN.
module tb_serial_to_parallel_converter;

    localparam int unsigned N = 4;
`ifdef S2P_PARITY_EN
    localparam int WL = 5;
`else
    localparam int WL = 4;
`endif

    logic         clk;
    logic         rst;
    logic         ser_data;
    logic         ser_valid;
    logic         ser_ready;
    logic [N-1:0] par_data;
    logic         par_valid;
    logic         par_ready;
`ifdef S2P_PARITY_EN
    logic         par_err;
`endif

    serial_to_parallel_converter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .par_data  (par_data),
        .par_valid (par_valid),
        .par_ready (par_ready)
`ifdef S2P_PARITY_EN
        ,
        .par_err   (par_err)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int stalls = 0;
    logic [4:0] sb[$];      // {expected err, expected data}
    int out_cyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: every word transfer is compared against the scoreboard head.
    always @(negedge clk) begin
        logic [4:0] e;
        if (!rst && par_valid && par_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                check("par_data", 32'(par_data), 32'(e[3:0]));
`ifdef S2P_PARITY_EN
                check("par_err", 32'(par_err), 32'(e[4]));
`endif
                out_cyc.push_back(cyc);
            end
        end
    end

    // Drive one bit and return just after the edge that accepts it.
    task automatic send_bit(input logic b);
        logic r;
        ser_data  = b;
        ser_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            r = ser_ready;
            @(posedge clk);
            #1;
            if (r) return;
            stalls++;
        end
        check("ser_timeout", 32'(0), 32'(1));
    endtask

    task automatic idle(input int n);
        ser_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [3:0] w, input logic p, input int gap);
        for (int i = 3; i >= 0; i--) begin
            send_bit(w[i]);
            if (gap > 0 && i > 0) idle(gap);
        end
`ifdef S2P_PARITY_EN
        if (gap > 0) idle(gap);
        send_bit(p);
`endif
        sb.push_back({(^w) ^ p, w});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [3:0] w;
        rst       = 1'b1;
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        par_ready = 1'b1;

        // Reset behaviour
        @(negedge clk);
        check("rst_ser_ready", 32'(ser_ready), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_par_valid", 32'(par_valid), 32'(0));
        check("rst_par_data", 32'(par_data), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(ser_ready), 32'(1));
        @(posedge clk); #1;

        // Basic word with latency and single-cycle valid
        send_word(4'b1011, 1'b1, 0);
        ser_valid = 1'b0;
        @(negedge clk);
        check("basic_latency", 32'(par_valid), 32'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("basic_one_cycle", 32'(par_valid), 32'(0));
        @(posedge clk); #1;

        // Back-to-back words
        stalls = 0;
        n0 = out_cyc.size();
        send_word(4'b1011, 1'b1, 0);
        send_word(4'b1101, 1'b1, 0);
        send_word(4'b0110, 1'b0, 0);
        idle(3);
        check("b2b_stalls", 32'(stalls), 32'(0));
        check("b2b_count", 32'(out_cyc.size() - n0), 32'(3));
        if (out_cyc.size() - n0 == 3) begin
            check("b2b_gap1", 32'(out_cyc[n0+1] - out_cyc[n0]), 32'(WL));
            check("b2b_gap2", 32'(out_cyc[n0+2] - out_cyc[n0+1]), 32'(WL));
        end

        // Backpressure: first word held, completing bit of the second stalls
        par_ready = 1'b0;
        n0 = out_cyc.size();
        send_word(4'b1011, 1'b1, 0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
`ifdef S2P_PARITY_EN
        send_bit(1'b1);
`endif
        ser_data  = 1'b1;
        ser_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("bp_ser_ready", 32'(ser_ready), 32'(0));
            check("bp_valid_held", 32'(par_valid), 32'(1));
            check("bp_data_held", 32'(par_data), 32'(4'b1011));
            @(posedge clk); #1;
        end
        par_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(ser_ready), 32'(1));
        @(posedge clk); #1;
        sb.push_back({1'b0, 4'b1101});
        ser_valid = 1'b0;
        @(negedge clk);
        check("bp_no_bubble", 32'(par_valid), 32'(1));
        @(posedge clk); #1;
        check("bp_count", 32'(out_cyc.size() - n0), 32'(2));
        if (out_cyc.size() - n0 == 2)
            check("bp_spacing", 32'(out_cyc[n0+1] - out_cyc[n0]), 32'(1));

        // Gaps between bits
        n0 = out_cyc.size();
        send_word(4'b0110, 1'b0, 3);
        idle(4);
        check("gap_count", 32'(out_cyc.size() - n0), 32'(1));

        // Reset mid-word discards the partial word
        send_bit(1'b1);
        send_bit(1'b0);
        ser_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", 32'(ser_ready), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        n0 = out_cyc.size();
        send_word(4'b1101, 1'b1, 0);
        idle(3);
        check("midrst_count", 32'(out_cyc.size() - n0), 32'(1));

`ifdef S2P_PARITY_EN
        // Parity good and bad
        send_word(4'b1011, 1'b1, 0);
        send_word(4'b1011, 1'b0, 0);
        idle(3);
`endif

        // Random words with random inter-bit gaps
        n0 = out_cyc.size();
        for (int k = 0; k < 6; k++) begin
            w = 4'($urandom_range(0, 15));
            send_word(w, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end
        idle(4);
        check("rand_count", 32'(out_cyc.size() - n0), 32'(6));

        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel_converter.md
SERIAL_TO_PARALLEL_CONVERTER -- requirements
Module: serial_to_parallel_converter

Interface
REQ-001 SHALL have parameter: N, default 4, parallel word width in bits (N >= 2).
REQ-002 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: ser_data  input  1  serial data bit.
REQ-005 SHALL have port: ser_valid  input  1  ser_data valid this cycle.
REQ-006 SHALL have port: ser_ready  output  1  converter accepts ser_data this cycle.
REQ-007 SHALL have port: par_data  output  N  assembled parallel word, registered.
REQ-008 SHALL have port: par_valid  output  1  par_data holds a complete word.
REQ-009 SHALL have port: par_ready  input  1  downstream accepts par_data this cycle.
REQ-010 SHALL have port (S2P_PARITY_EN only): par_err  output  1  parity mismatch for the word in par_data, qualified by par_valid.

Function
REQ-011 SHALL transfer a serial bit only when ser_valid && ser_ready, and a word only when par_valid && par_ready.
REQ-012 SHALL shift bits MSB-first: first accepted bit lands in par_data[N-1], last in par_data[0].
REQ-013 SHALL count accepted bits with a counter of width $clog2(N+1), wrapping to 0 after the final bit of a word.
REQ-014 SHALL use FSM states S_DATA (collect N data bits) and S_PARITY (collect parity bit, parity build only); S_DATA -> S_PARITY on Nth bit, S_PARITY -> S_DATA on parity bit; without parity S_DATA loops.
REQ-015 SHALL load the output register and assert par_valid on the cycle after the final bit of a word is accepted (latency 1 clk).
REQ-016 SHALL hold par_data/par_valid stable while par_valid && !par_ready.
REQ-017 SHALL deassert par_valid after a par transfer unless a new word loads the same cycle.
REQ-018 SHALL keep ser_ready=1 at all times except when the next accepted bit would complete a word while par_valid && !par_ready; then ser_ready=0.
REQ-019 SHALL, on simultaneous word completion and par transfer, load the new word with par_valid staying 1 (no bubble; sustained 1 word per N bits, N+1 with parity).
REQ-020 SHALL ignore ser_data when ser_valid=0; gaps of any length do not disturb partial words.

Reset
REQ-021 SHALL on rst=1 at a clock edge set: par_valid=0, par_data=0, par_err=0, counter=0, state=S_DATA, shift register=0.
REQ-022 SHALL drive ser_ready=0 during the reset cycle and 1 on the first cycle after rst deasserts.
REQ-023 SHALL discard a partial word on reset mid-operation; the next accepted bit is the MSB of a new word.

Configuration
REQ-024 SHALL support macro S2P_PARITY_EN: defined -> each word is N data bits plus one even-parity bit, par_err=1 when XOR of data and parity bits is 1; the word is still delivered.
REQ-025 SHALL, with S2P_PARITY_EN undefined, omit the par_err port, S_PARITY state and parity logic entirely.

Structure
REQ-026 SHALL place the FSM state enum (S_DATA, S_PARITY) and the counter width function in package s2p_pkg.
REQ-027 SHALL be a single module with no sub-modules; shift register, counter, FSM and output register are inline.

Verification
REQ-028 SHALL cover basic word: N=4, par_ready=1, bits 1,0,1,1 on consecutive cycles -> par_valid=1 for one cycle with par_data=4'b1011, one cycle after the 4th bit.
REQ-029 SHALL cover back-to-back: streams 1011,1101,0110 with no gaps -> three words on par_data at 4-cycle spacing, ser_ready constantly 1.
REQ-030 SHALL cover backpressure: par_ready=0, send 1011 then 1101 -> 1011 held; ser_ready=0 while presenting the 4th bit of 1101; raise par_ready -> 1011 transfers, then 1101 appears next cycle.
REQ-031 SHALL cover gaps: 0110 sent with ser_valid low 3 cycles between each bit -> par_data=4'b0110 exactly once.
REQ-032 SHALL cover reset mid-word: 2 bits of 1011, rst pulse, then 1101 -> only 4'b1101 is output.
REQ-033 SHALL cover S2P_PARITY_EN: 1011+parity 1 -> par_err=0; 1011+parity 0 -> par_err=1, par_data=4'b1011.
